// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the processor and the pixel reader,
// processor first, with a streak counter bounding how long the pixel reader can be starved.
module dmem_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              pix_req,
   input  logic [ADDR_W-1:0] pix_addr,
   output logic              pix_gnt,
   output logic              pix_rvalid,
   output logic [DATA_W-1:0] pix_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic [SW-1:0] streak_q, streak_d;
   logic          rd_cpu_q, rd_cpu_d;
   logic          rd_pix_q, rd_pix_d;
   logic          cpu_gnt;

   always_comb begin
      cpu_gnt    = cpu_req & ~(pix_req & (streak_q == LIMIT));
      pix_gnt    = pix_req & ~cpu_gnt;
      cpu_stall  = cpu_req & ~cpu_gnt;
      mem_en     = cpu_gnt | pix_gnt;
      mem_we     = cpu_gnt & cpu_we;
      mem_addr   = cpu_gnt ? cpu_addr : pix_gnt ? pix_addr : '0;
      mem_wdata  = cpu_gnt ? cpu_wdata : '0;
      // the streak only grows while the pixel reader is actually waiting
      streak_d   = (cpu_gnt & pix_req) ? ((streak_q == LIMIT) ? streak_q : streak_q + 1'b1) : '0;
      rd_cpu_d   = cpu_gnt & ~cpu_we;
      rd_pix_d   = pix_gnt;
      cpu_rvalid = rd_cpu_q;
      pix_rvalid = rd_pix_q;
      cpu_rdata  = rd_cpu_q ? mem_rdata : '0;
      pix_rdata  = rd_pix_q ? mem_rdata : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_q <= '0;
         rd_cpu_q <= 1'b0;
         rd_pix_q <= 1'b0;
      end else begin
         streak_q <= streak_d;
         rd_cpu_q <= rd_cpu_d;
         rd_pix_q <= rd_pix_d;
      end
   end
endmodule
